// File: rtl/tt_um_uart_rx.sv
// rtl/tt_um_uart_rx.sv - 8N1 UART receiver with valid/overrun/framing flags and consumer ack.
// Optional macro INVERT_RX_EN: idle-low line with inverted data on the wire.
module tt_um_uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    wire unused = &{1'b0, ena, ui_in[7:1], uio_in[7:2], uio_in[0]};

    logic rx_raw;
`ifdef INVERT_RX_EN
    assign rx_raw = ~ui_in[0];
`else
    assign rx_raw = ui_in[0];
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data, data_n;
    logic          valid, valid_n;
    logic          ovr, ovr_n;
    logic          fe, fe_n;
    logic          rx_s1, rx_s2;
    logic          ack_s1, ack_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            ack_s1  <= 1'b0;
            ack_s2  <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data    <= '0;
            valid   <= 1'b0;
            ovr     <= 1'b0;
            fe      <= 1'b0;
        end else begin
            rx_s1   <= rx_raw;
            rx_s2   <= rx_s1;
            ack_s1  <= uio_in[1];
            ack_s2  <= ack_s1;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            data    <= data_n;
            valid   <= valid_n;
            ovr     <= ovr_n;
            fe      <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        data_n  = data;
        valid_n = valid;
        ovr_n   = ovr;
        fe_n    = fe;
        if (ack_s2) begin
            valid_n = 1'b0;
            ovr_n   = 1'b0;
            fe_n    = 1'b0;
        end
        case (state)
            IDLE: begin
                if (!rx_s2) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // Mid-bit recheck rejects glitches shorter than half a bit.
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s2 ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    shift_n = {rx_s2, shift[7:1]};
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n = '0;
                    if (rx_s2) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        // A same-cycle ack consumes the old byte, so no overrun.
                        ovr_n   = ovr_n | (valid & ~ack_s2);
                        fe_n    = 1'b0;
                        state_n = IDLE;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_s2) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign uo_out  = data;
    assign uio_out = {5'b0, fe, ovr, valid};
    assign uio_oe  = 8'b0000_0111;
endmodule
